// File: rtl/result_select_unit.sv
// Registered valid/ready result selector (ALU/HI/LO/shifter by function code); holds MFHI/MFLO while div_busy.
// Optional illegal-code flag output enabled by RESULT_SELECT_ILLEGAL_FLAG_EN.
module result_select_unit #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   hi_out,
  input  logic [WIDTH-1:0]   lo_out,
  input  logic [WIDTH-1:0]   shifter_out,
  input  logic [FUNCT_W-1:0] signal,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               div_busy,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_valid,
`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
  output logic               illegal_op,
`endif
  input  logic               out_ready
);

  localparam logic [FUNCT_W-1:0] FN_AND  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_SLT  = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] FN_MFHI = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] FN_MFLO = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] FN_SRL  = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] FN_DIVU = FUNCT_W'(6'b011011);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DIV = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t             state;
  logic [FUNCT_W-1:0] storedCode;
  logic [WIDTH-1:0]   selData;
  logic [WIDTH-1:0]   releaseData;
  logic               isHiLo;
  logic               stallReq;
  logic               accept;

  assign in_ready = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    selData = '0;
    case (signal)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: selData = alu_out;
      FN_MFHI: selData = hi_out;
      FN_MFLO: selData = lo_out;
      FN_SRL:  selData = shifter_out;
      default: selData = '0;
    endcase
  end

  assign isHiLo      = (signal == FN_MFHI) || (signal == FN_MFLO);
  assign stallReq    = isHiLo && div_busy;
  // HI/LO are read at the release edge so the finished divide result is returned.
  assign releaseData = (storedCode == FN_MFHI) ? hi_out : lo_out;

`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
  logic selIllegal;

  always_comb begin
    selIllegal = 1'b1;
    case (signal)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
      FN_MFHI, FN_MFLO, FN_SRL, FN_DIVU: selIllegal = 1'b0;
      default: selIllegal = 1'b1;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_out   <= '0;
      out_valid  <= 1'b0;
      storedCode <= '0;
`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (stallReq) begin
              storedCode <= signal;
              out_valid  <= 1'b0;
              state      <= WAIT_DIV;
            end else begin
              data_out   <= selData;
              out_valid  <= 1'b1;
`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
              illegal_op <= selIllegal;
`endif
              state      <= HOLD;
            end
          end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        WAIT_DIV: begin
          if (!div_busy) begin
            data_out   <= releaseData;
            out_valid  <= 1'b1;
`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
            illegal_op <= 1'b0;
`endif
            state      <= HOLD;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_select_unit.sv
// Directed bench for result_select_unit: select codes, divider stall, back-to-back, backpressure, async reset.
module tb_result_select_unit;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] shifter_out;
  logic [5:0]  signal;
  logic        in_valid;
  logic        in_ready;
  logic        div_busy;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready;
`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
  logic        illegal_op;
`endif

  int checks = 0;
  int errors = 0;
  int badCnt;

  localparam logic [5:0] C_AND  = 6'b100100;
  localparam logic [5:0] C_OR   = 6'b100101;
  localparam logic [5:0] C_ADD  = 6'b100000;
  localparam logic [5:0] C_SUB  = 6'b100010;
  localparam logic [5:0] C_MFHI = 6'b010000;
  localparam logic [5:0] C_MFLO = 6'b010010;
  localparam logic [5:0] C_SRL  = 6'b000010;
  localparam logic [5:0] C_DIVU = 6'b011011;
  localparam logic [5:0] C_BAD  = 6'b111111;

  result_select_unit #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_out    (alu_out),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .shifter_out(shifter_out),
    .signal     (signal),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_busy   (div_busy),
    .data_out   (data_out),
    .out_valid  (out_valid),
`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
    .illegal_op (illegal_op),
`endif
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; alu_out = '0; hi_out = '0; lo_out = '0; shifter_out = '0;
    signal = '0; in_valid = 1'b0; div_busy = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    checkVal("rst_data", data_out, 32'h0);
    checkVal("rst_valid", {31'b0, out_valid}, 32'h0);
    checkVal("rst_in_ready", {31'b0, in_ready}, 32'h0);
    cyc(); cyc();
    rst = 1'b0;

    // ADD, one-cycle latency, then drop to idle
    signal = C_ADD; alu_out = 32'h5; in_valid = 1'b1; out_ready = 1'b1;
    #1 checkVal("idle_in_ready", {31'b0, in_ready}, 32'h1);
    cyc();
    in_valid = 1'b0;
    checkVal("add_data", data_out, 32'h5);
    checkVal("add_valid", {31'b0, out_valid}, 32'h1);
    cyc();
    checkVal("add_valid_drop", {31'b0, out_valid}, 32'h0);

    // MFHI stalled by divider for 32 cycles
    signal = C_MFHI; hi_out = 32'h0; div_busy = 1'b1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    badCnt = 0;
    for (int i = 0; i < 31; i++) begin
      hi_out = 32'h100 + i;
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) badCnt++;
      cyc();
    end
    checkVal("stall_ready_valid", badCnt, 32'h0);
    div_busy = 1'b0; hi_out = 32'h7;
    #1 checkVal("stall_in_ready_last", {31'b0, in_ready}, 32'h0);
    cyc();
    checkVal("mfhi_valid", {31'b0, out_valid}, 32'h1);
    checkVal("mfhi_data", data_out, 32'h7);
    cyc();
    checkVal("mfhi_valid_drop", {31'b0, out_valid}, 32'h0);

    // back-to-back SRL, MFLO, SUB
    signal = C_SRL; shifter_out = 32'h0F; in_valid = 1'b1;
    cyc();
    signal = C_MFLO; lo_out = 32'hAA;
    #1;
    checkVal("b2b_srl", data_out, 32'h0F);
    checkVal("b2b_in_ready1", {31'b0, in_ready}, 32'h1);
    cyc();
    signal = C_SUB; alu_out = 32'hFFFF_FFFF;
    #1;
    checkVal("b2b_mflo", data_out, 32'hAA);
    checkVal("b2b_valid2", {31'b0, out_valid}, 32'h1);
    checkVal("b2b_in_ready2", {31'b0, in_ready}, 32'h1);
    cyc();
    in_valid = 1'b0;
    #1;
    checkVal("b2b_sub", data_out, 32'hFFFF_FFFF);
    checkVal("b2b_valid3", {31'b0, out_valid}, 32'h1);
    cyc();
    checkVal("b2b_valid_drop", {31'b0, out_valid}, 32'h0);

    // backpressure on OR result
    signal = C_OR; alu_out = 32'h1234; in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    badCnt = 0;
    for (int i = 0; i < 5; i++) begin
      alu_out = 32'h1000 + i;
      #1;
      if (data_out !== 32'h1234 || in_ready !== 1'b0 || out_valid !== 1'b1) badCnt++;
      cyc();
    end
    checkVal("bp_hold", badCnt, 32'h0);
    checkVal("bp_data", data_out, 32'h1234);
    out_ready = 1'b1;
    #1 checkVal("bp_in_ready_release", {31'b0, in_ready}, 32'h1);
    cyc();
    checkVal("bp_released", {31'b0, out_valid}, 32'h0);

    // DIVU and unknown code both give zero
    alu_out = 32'h55; hi_out = 32'h66; lo_out = 32'h77; shifter_out = 32'h88;
    signal = C_DIVU; in_valid = 1'b1;
    cyc();
    signal = C_BAD;
    checkVal("divu_data", data_out, 32'h0);
    checkVal("divu_valid", {31'b0, out_valid}, 32'h1);
`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
    checkVal("divu_illegal", {31'b0, illegal_op}, 32'h0);
`endif
    cyc();
    in_valid = 1'b0;
    checkVal("bad_data", data_out, 32'h0);
    checkVal("bad_valid", {31'b0, out_valid}, 32'h1);
`ifdef RESULT_SELECT_ILLEGAL_FLAG_EN
    checkVal("bad_illegal", {31'b0, illegal_op}, 32'h1);
`endif
    cyc();

    // async reset during WAIT_DIV
    signal = C_AND; alu_out = 32'hF0; in_valid = 1'b1;
    cyc();
    checkVal("and_pre_data", data_out, 32'hF0);
    signal = C_MFHI; hi_out = 32'h99; div_busy = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    #1 rst = 1'b1;
    #1;
    checkVal("arst_data", data_out, 32'h0);
    checkVal("arst_valid", {31'b0, out_valid}, 32'h0);
    checkVal("arst_in_ready", {31'b0, in_ready}, 32'h0);
    div_busy = 1'b0;
    cyc();
    rst = 1'b0;
    badCnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (out_valid !== 1'b0 || data_out !== 32'h0) badCnt++;
    end
    checkVal("no_stale_mfhi", badCnt, 32'h0);
    signal = C_AND; alu_out = 32'h3C; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    checkVal("post_rst_and_data", data_out, 32'h3C);
    checkVal("post_rst_and_valid", {31'b0, out_valid}, 32'h1);
    cyc();
    checkVal("post_rst_valid_drop", {31'b0, out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_select_unit.md
Name: result_select_unit

Overview:
- Registered, handshaked result-select stage for the ALU datapath.
- Picks ALU, HI, LO or shifter result by 6-bit function code, like the combinational selector it replaces.
- Adds three things over that selector:
  - width parametrisation;
  - valid/ready flow control;
  - a stall so MFHI/MFLO never return HI/LO while the divider is still computing.
- Sits between the ALU/HiLo/Shifter blocks and the writeback/testbench sink.

Parameters:
- WIDTH, 32, datapath width of all data inputs and data_out.
- FUNCT_W, 6, width of the function code.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_out  input  WIDTH  ALU result.
- hi_out  input  WIDTH  HI register value.
- lo_out  input  WIDTH  LO register value.
- shifter_out  input  WIDTH  shifter result.
- signal  input  FUNCT_W  function code of the request.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid & in_ready.
- div_busy  input  1  high while DIVU is computing; HI/LO are invalid.
- data_out  output  WIDTH  selected result, registered.
- out_valid  output  1  data_out holds a result.
- out_ready  input  1  sink takes the result when out_valid & out_ready.

Behaviour:
- Function codes:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 -> alu_out.
  - MFHI 010000 -> hi_out.
  - MFLO 010010 -> lo_out.
  - SRL 000010 -> shifter_out.
  - DIVU 011011 and any other code -> all-zero result. The request still completes normally.
- Reset (async, any state): state=IDLE, data_out=0, out_valid=0, stored code=0, in_ready=0 while rst is high. Reset during WAIT_DIV drops the pending request; no output is produced for it.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is combinational; it does not depend on in_valid.
- State IDLE, on accept:
  - if code is MFHI/MFLO and div_busy=1: store the code, go to WAIT_DIV;
  - otherwise: data_out <= selected value, go to HOLD.
- State IDLE, no accept: stay in IDLE.
- State WAIT_DIV:
  - in_ready=0;
  - each cycle, sample div_busy;
  - on the first edge with div_busy=0, data_out <= hi_out or lo_out per the stored code, go to HOLD.
- State HOLD:
  - out_valid=1, and data_out is stable while out_ready=0;
  - on out_ready=1 with a new accept: handle the new request exactly as in IDLE. This gives back-to-back throughput of 1 result per cycle.
  - on out_ready=1 with no accept: go to IDLE, out_valid <= 0.
- Latency:
  - non-stalled request: out_valid rises on the edge that accepts the request, i.e. visible the next cycle;
  - stalled request: out_valid rises on the first edge where div_busy=0 is sampled.
- Data sampling:
  - data inputs are sampled only on the capture edge; later input changes do not affect a held result;
  - HI/LO are read at the release edge, not at accept.
- div_busy rising while in HOLD does not affect a held result.
- All arithmetic is pure selection; no width conversion. Unknown codes yield {WIDTH{1'b0}}.

Optional Feature:
- Macro: RESULT_SELECT_ILLEGAL_FLAG_EN.
- When defined:
  - adds output illegal_op (1 bit);
  - illegal_op is registered with data_out and reset to 0;
  - it is 1 when the captured code is not one of the nine listed codes (DIVU counts as legal);
  - it holds/clears under the same rules as data_out.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Reset, then ADD with alu_out=0x0000_0005, out_ready=1 -> next cycle data_out=0x5, out_valid=1; following cycle with no request -> out_valid=0.
- MFHI accepted with div_busy=1 for 32 cycles, hi_out changing to 0x0000_0007 when div_busy drops -> in_ready=0 throughout, out_valid=1 the cycle after div_busy=0 is sampled, data_out=0x7.
- Back-to-back stream with out_ready=1:
  - stimulus SRL (shifter_out=0x0F), MFLO (lo_out=0xAA, div_busy=0), SUB (alu_out=0xFFFF_FFFF);
  - response: three consecutive out_valid cycles with 0x0F, 0xAA, 0xFFFF_FFFF; in_ready stays 1.
- Backpressure: OR result 0x1234 held with out_ready=0 for 5 cycles while alu_out changes -> data_out stays 0x1234, in_ready=0; out_ready=1 releases it.
- DIVU code and code 111111 -> data_out=0, out_valid=1; with RESULT_SELECT_ILLEGAL_FLAG_EN, illegal_op=0 for DIVU and 1 for 111111.
- Assert rst in the middle of WAIT_DIV -> data_out=0, out_valid=0 immediately (async); after release, no stale MFHI result appears; a new AND request completes normally.
